// File: rtl/seg7_pkg.sv
// Shared glyph table and polarity helpers for the 7-segment scan driver.
// Glyphs are stored active-high in gfedcba order; polarity is applied at the pins.
package seg7_pkg;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg7_polar(input logic [6:0] glyph, input logic actLow);
        return actLow ? ~glyph : glyph;
    endfunction

    function automatic logic [6:0] SEG_OFF(input logic actLow);
        return seg7_polar(7'h00, actLow);
    endfunction

    function automatic logic [6:0] SEG_ON(input logic actLow);
        return seg7_polar(7'h7F, actLow);
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational hex nibble to active-high gfedcba glyph lookup.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] iNibble,
    output logic [6:0] oGlyph
);

    assign oGlyph = GLYPH[iNibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment bank driver: slot/digit/frame counters, frame-synchronous
// shadow capture, leading-zero blanking, blink, PWM brightness and registered pins.
module seg7_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int PRESCALE_W  = 10,
    parameter int BRIGHT_W    = 3,
    parameter int BLINK_W     = 5,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  iEN,
    input  logic [4*DIGITS-1:0]   iVALUE,
    input  logic [DIGITS-1:0]     iDP,
    input  logic [DIGITS-1:0]     iBLINK,
    input  logic                  iLZB,
    input  logic [BRIGHT_W-1:0]   iBRIGHT,
    output logic [6:0]            oSEG,
    output logic                  oDP,
    output logic [DIGITS-1:0]     oAN,
    output logic                  oFRAME
);
    import seg7_pkg::*;

    localparam int                    DIG_W    = $clog2(DIGITS);
    localparam logic [DIG_W-1:0]      DIG_LAST = DIG_W'(DIGITS - 1);
    localparam logic [PRESCALE_W-1:0] PRE_LAST = '1;
    localparam logic [6:0]            SEG_DARK = SEG_OFF(SEG_ACT_LOW);
    localparam logic                  DP_DARK  = SEG_ACT_LOW;
    localparam logic [DIGITS-1:0]     AN_DARK  = AN_ACT_LOW ? '1 : '0;

    logic [PRESCALE_W-1:0] preCnt;
    logic [DIG_W-1:0]      digIdx;
    logic [BLINK_W-1:0]    frmCnt;
    logic [4*DIGITS-1:0]   shValue;
    logic [DIGITS-1:0]     shDp;
    logic [DIGITS-1:0]     shBlink;
    logic                  shLzb;

    logic [DIGITS-1:0]     anReg;
    logic [6:0]            segReg;
    logic                  dpReg;
    logic                  frameReg;

    logic preWrap;
    logic digWrap;
    assign preWrap = (preCnt == PRE_LAST);
    assign digWrap = preWrap && (digIdx == DIG_LAST);

    // Counters and shadows; shadows only move at the frame boundary so a frame never tears.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            preCnt   <= '0;
            digIdx   <= '0;
            frmCnt   <= '0;
            shValue  <= '0;
            shDp     <= '0;
            shBlink  <= '0;
            shLzb    <= 1'b0;
            frameReg <= 1'b0;
        end else begin
            preCnt   <= preCnt + 1'b1;
            frameReg <= digWrap;
            if (preWrap) begin
                digIdx <= digWrap ? '0 : digIdx + 1'b1;
            end
            if (digWrap) begin
                frmCnt  <= frmCnt + 1'b1;
                shValue <= iVALUE;
                shDp    <= iDP;
                shBlink <= iBLINK;
                shLzb   <= iLZB;
            end
        end
    end

    // keepBlank[d]: digit d and every digit above it are blankable leading zeros.
    logic [DIGITS:0] keepBlank;
    assign keepBlank[DIGITS] = shLzb;
    assign keepBlank[0]      = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < DIGITS; gi++) begin : g_lzb
            assign keepBlank[gi] = keepBlank[gi+1] && (shValue[4*gi +: 4] == 4'h0) && !shDp[gi];
        end
    endgenerate

    logic [3:0] curNibble;
    logic [6:0] curGlyph;
    assign curNibble = shValue[4*int'(digIdx) +: 4];

    seg7_glyph u_glyph (
        .iNibble (curNibble),
        .oGlyph  (curGlyph)
    );

    logic              slotOn;
    logic [DIGITS-1:0] oneHot;
    logic [DIGITS-1:0] anNext;
    logic [6:0]        segNext;
    logic              dpNext;

    always_comb begin
        oneHot  = {{(DIGITS-1){1'b0}}, 1'b1} << digIdx;
        slotOn  = iEN
               && (preCnt != '0)
               && (preCnt[PRESCALE_W-1 -: BRIGHT_W] <= iBRIGHT)
               && !(shBlink[digIdx] && frmCnt[BLINK_W-1])
               && !keepBlank[digIdx];
        anNext  = AN_DARK;
        segNext = SEG_DARK;
        dpNext  = DP_DARK;
        if (slotOn) begin
            anNext  = AN_ACT_LOW ? ~oneHot : oneHot;
            segNext = seg7_polar(curGlyph, SEG_ACT_LOW);
            dpNext  = shDp[digIdx] ^ SEG_ACT_LOW;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            anReg  <= AN_DARK;
            segReg <= SEG_DARK;
            dpReg  <= DP_DARK;
        end else begin
            anReg  <= anNext;
            segReg <= segNext;
            dpReg  <= dpNext;
        end
    end

    assign oAN    = anReg;
    assign oSEG   = segReg;
    assign oDP    = dpReg;
    assign oFRAME = frameReg;

endmodule
